// File: rtl/mem_master_if.sv
// Request/response handshake and word-wide memory port for mem_master.
// The master modport is the view from mem_master; the slave modport is the core and memory side.
interface mem_master_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic             req_valid;
  logic             req_ready;
  logic             req_write;
  logic [1:0]       req_size;
  logic             req_signed;
  logic [WIDTH-1:0] req_adr;
  logic [WIDTH-1:0] req_wdata;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_rdata;
  logic             rsp_err;
  logic             memwrite;
  logic [WIDTH-1:0] adr;
  logic [WIDTH-1:0] writedata;
  logic [WIDTH-1:0] memdata;

  modport master (
    input  req_valid, req_write, req_size, req_signed, req_adr, req_wdata, rsp_ready, memdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, memwrite, adr, writedata
  );

  modport slave (
    output req_valid, req_write, req_size, req_signed, req_adr, req_wdata, rsp_ready, memdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, memwrite, adr, writedata
  );
endinterface

// File: rtl/mem_master.sv
// mem_master: bus-master end of the external memory interface.
// The memory only does aligned full-word accesses. This block aligns the address, extracts
// big-endian byte/halfword load lanes, and does sub-word stores by read-modify-write.
// Misaligned or illegal-size requests get an error response with no memory access.
// Define MEM_MASTER_STATS_EN to enable the saturating rd/wr/err response counters.
module mem_master #(
  parameter int unsigned WIDTH = 32,  // only 32 is supported
  parameter int unsigned RDLAT = 1    // cycles from driving adr to sampling memdata, 1..4
) (
  input  logic         clk,
  input  logic         reset_n,
  mem_master_if.master bus,
  output logic [15:0]  rd_count,
  output logic [15:0]  wr_count,
  output logic [15:0]  err_count
);

  typedef enum logic [2:0] {StIdle, StRwait, StMerge, StWrite, StResp} state_e;

  state_e           state_q, state_d;
  logic             write_q, write_d;
  logic [1:0]       size_q, size_d;
  logic             signed_q, signed_d;
  logic [1:0]       off_q, off_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [WIDTH-1:0] adr_q, adr_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] wrdata_q, wrdata_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             misaligned;

  // Big-endian lane select: byte offset 0 lives in bits 31:24, halfword offset 0 in 31:16.
  function automatic logic [31:0] load_lane(input logic [31:0] w, input logic [1:0] sz,
                                            input logic [1:0] off, input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{~off, 3'b000} +: 8];
    h = w[{~off[1], 4'b0000} +: 16];
    case (sz)
      2'b00:   load_lane = {{24{sgn & b[7]}}, b};
      2'b01:   load_lane = {{16{sgn & h[15]}}, h};
      default: load_lane = w;
    endcase
  endfunction

  // Replace only the addressed lane; every other bit of the memory word is kept.
  function automatic logic [31:0] merge_lane(input logic [31:0] w, input logic [1:0] sz,
                                             input logic [1:0] off, input logic [31:0] d);
    logic [31:0] m;
    m = w;
    if (sz == 2'b00) m[{~off, 3'b000} +: 8] = d[7:0];
    else             m[{~off[1], 4'b0000} +: 16] = d[15:0];
    return m;
  endfunction

  assign misaligned = (bus.req_size == 2'b11) ||
                      (bus.req_size == 2'b01 && bus.req_adr[0]) ||
                      (bus.req_size == 2'b10 && bus.req_adr[1:0] != 2'b00);

  // Next-state and datapath update for the access sequencer.
  always_comb begin
    state_d  = state_q;
    write_d  = write_q;
    size_d   = size_q;
    signed_d = signed_q;
    off_d    = off_q;
    wdata_d  = wdata_q;
    adr_d    = adr_q;
    word_d   = word_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    wrdata_d = wrdata_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          write_d  = bus.req_write;
          size_d   = bus.req_size;
          signed_d = bus.req_signed;
          off_d    = bus.req_adr[1:0];
          wdata_d  = bus.req_wdata;
          adr_d    = {bus.req_adr[WIDTH-1:2], 2'b00};
          rdata_d  = '0;
          err_d    = 1'b0;
          cnt_d    = '0;
          if (misaligned) begin
            err_d   = 1'b1;
            state_d = StResp;
          end else if (bus.req_write && bus.req_size == 2'b10) begin
            wrdata_d = bus.req_wdata;
            state_d  = StWrite;
          end else begin
            state_d = StRwait;
          end
        end
      end
      StRwait: begin
        if (cnt_q == 2'(RDLAT - 1)) begin
          word_d = bus.memdata;
          if (write_q) begin
            state_d = StMerge;
          end else begin
            rdata_d = load_lane(bus.memdata, size_q, off_q, signed_q);
            state_d = StResp;
          end
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      StMerge: begin
        wrdata_d = merge_lane(word_q, size_q, off_q, wdata_q);
        state_d  = StWrite;
      end
      StWrite: state_d = StResp;
      StResp:  if (bus.rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset abandons any access in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      write_q  <= 1'b0;
      size_q   <= 2'b00;
      signed_q <= 1'b0;
      off_q    <= 2'b00;
      wdata_q  <= '0;
      adr_q    <= '0;
      word_q   <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      wrdata_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      write_q  <= write_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      off_q    <= off_d;
      wdata_q  <= wdata_d;
      adr_q    <= adr_d;
      word_q   <= word_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      wrdata_q <= wrdata_d;
      cnt_q    <= cnt_d;
    end
  end

  // memwrite decodes straight from the state flop so it drops the instant reset_n falls.
  assign bus.req_ready = (state_q == StIdle);
  assign bus.rsp_valid = (state_q == StResp);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign bus.memwrite  = (state_q == StWrite);
  assign bus.adr       = adr_q;
  assign bus.writedata = wrdata_q;

`ifdef MEM_MASTER_STATS_EN
  logic [15:0] rd_cnt_q, wr_cnt_q, err_cnt_q;
  logic        rsp_fire;

  assign rsp_fire = (state_q == StResp) && bus.rsp_ready;

  // Count completed responses by kind; an error only counts as an error.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
      err_cnt_q <= '0;
    end else if (rsp_fire) begin
      if (err_q) begin
        if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
      end else if (write_q) begin
        if (wr_cnt_q != 16'hFFFF) wr_cnt_q <= wr_cnt_q + 16'd1;
      end else begin
        if (rd_cnt_q != 16'hFFFF) rd_cnt_q <= rd_cnt_q + 16'd1;
      end
    end
  end

  assign rd_count  = rd_cnt_q;
  assign wr_count  = wr_cnt_q;
  assign err_count = err_cnt_q;
`else
  assign rd_count  = '0;
  assign wr_count  = '0;
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_mem_master.sv
// Scoreboard bench for mem_master: the driver predicts each response from a byte-level
// memory model and queues it; an independent monitor checks whatever the DUT presents.
module tb_mem_master;
  localparam int unsigned RDLAT = 1;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] rd_count, wr_count, err_count;

  mem_master_if #(.WIDTH(32)) bus ();

  mem_master #(.WIDTH(32), .RDLAT(RDLAT)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus),
    .rd_count (rd_count),
    .wr_count (wr_count),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  // External word memory seen by the DUT: combinational read, write on the clock edge.
  logic [31:0] mem [1024];
  assign bus.memdata = mem[bus.adr[11:2]];
  always @(posedge clk) if (bus.memwrite) mem[bus.adr[11:2]] <= bus.writedata;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] <= '0;
    mem[0] <= 32'h20030000;
    mem[1] <= 32'h20040014;
    mem[6] <= 32'ha00300ff;
  end

  // Reference memory as plain bytes, most significant byte at the lowest address.
  logic [7:0] rb [4096];

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          writes;
    logic [31:0] wadr;
    int          kind;  // 0 load, 1 store, 2 error
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0, n_bad = 0;
  int   cyc = 0, acc_edge = 0, wr_seen = 0;
  int   cnt_rd = 0, cnt_wr = 0, cnt_err = 0;
  bit   seen = 0, mon_en = 0, rnd_rdy = 0, force_rdy = 1;
  logic [31:0] first_rd;
  logic        first_err;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endfunction

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input int n, input logic sgn);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v = (v << 8) | 32'(rb[int'((a + 32'(i)) & 32'hFFF)]);
    if (sgn && n < 4 && v[8*n-1]) v = v | (32'hFFFFFFFF << (8 * n));
    return v;
  endfunction

  function automatic void ref_store(input logic [31:0] a, input int n, input logic [31:0] d);
    logic [31:0] s;
    for (int i = 0; i < n; i++) begin
      s = d >> (8 * (n - 1 - i));
      rb[int'((a + 32'(i)) & 32'hFFF)] = s[7:0];
    end
  endfunction

  // Drive one request, predicting its response; use_k substitutes a literal expected value.
  task automatic issue(input logic wr, input logic [1:0] sz, input logic sgn, input logic [31:0] a,
                       input logic [31:0] wd, input bit use_k, input logic [31:0] k);
    exp_t e;
    int   n;
    bit   ok;
    n = nbytes(sz);
    e.wadr = {a[31:2], 2'b00};
    if (sz == 2'b11 || (a % 32'(n)) != 0) begin
      e.err = 1'b1; e.rdata = '0; e.lat = 1; e.writes = 0; e.kind = 2;
    end else if (wr) begin
      e.err = 1'b0; e.rdata = '0; e.writes = 1; e.kind = 1;
      e.lat = (n == 4) ? 2 : int'(RDLAT) + 3;
      ref_store(a, n, wd);
    end else begin
      e.err = 1'b0; e.writes = 0; e.kind = 0; e.lat = int'(RDLAT) + 1;
      e.rdata = ref_load(a, n, sgn);
    end
    if (use_k) e.rdata = k;
    q.push_back(e);
    bus.req_valid = 1'b1; bus.req_write = wr; bus.req_size = sz;
    bus.req_signed = sgn; bus.req_adr = a; bus.req_wdata = wd;
    ok = 0;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      if (bus.req_ready) ok = 1;
    end
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout: got req_ready 0, expected 1");
      void'(q.pop_back());
    end else begin
      @(posedge clk);
    end
    #1 bus.req_valid = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int t = 0; t < 500 && q.size() != 0; t++) tick(1);
    if (q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_timeout: got %0d pending, expected 0", q.size());
      q.delete();
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
    chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    chk({tag, "_rsp_rdata"}, bus.rsp_rdata, 32'd0);
    chk({tag, "_rsp_err"}, 32'(bus.rsp_err), 32'd0);
    chk({tag, "_memwrite"}, 32'(bus.memwrite), 32'd0);
    chk({tag, "_adr"}, bus.adr, 32'd0);
    chk({tag, "_writedata"}, bus.writedata, 32'd0);
    chk({tag, "_rd_count"}, 32'(rd_count), 32'd0);
    chk({tag, "_wr_count"}, 32'(wr_count), 32'd0);
    chk({tag, "_err_count"}, 32'(err_count), 32'd0);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Response consumer: random backpressure or a fixed level chosen by the stimulus.
  initial begin
    bus.rsp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1 bus.rsp_ready = rnd_rdy ? ($urandom_range(3) != 0) : force_rdy;
    end
  end

  // Monitor: checks latency, hold stability, write activity and response contents.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en && reset_n) begin
      if (bus.memwrite) begin
        wr_seen++;
        if (q.size() != 0) chk("write_adr", bus.adr, q[0].wadr);
        else chk("stray_write", 32'(bus.memwrite), 32'd0);
      end
      if (bus.req_valid && bus.req_ready) acc_edge = cyc + 1;
      if (bus.rsp_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_rsp", 32'(bus.rsp_valid), 32'd0);
        end else begin
          if (!seen) begin
            seen = 1; first_rd = bus.rsp_rdata; first_err = bus.rsp_err;
            chk("latency", 32'(cyc - acc_edge + 1), 32'(q[0].lat));
          end else begin
            chk("hold_rdata", bus.rsp_rdata, first_rd);
            chk("hold_err", 32'(bus.rsp_err), 32'(first_err));
          end
          if (bus.rsp_ready) begin
            e = q.pop_front();
            chk("rdata", bus.rsp_rdata, e.rdata);
            chk("err", 32'(bus.rsp_err), 32'(e.err));
            chk("writes", 32'(wr_seen), 32'(e.writes));
            if (e.kind == 0) cnt_rd++;
            else if (e.kind == 1) cnt_wr++;
            else cnt_err++;
            seen = 0; wr_seen = 0;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    logic [31:0] a;
    logic [1:0]  sz;
    bus.req_valid = 0; bus.req_write = 0; bus.req_size = 0;
    bus.req_signed = 0; bus.req_adr = 0; bus.req_wdata = 0;
    for (int i = 0; i < 4096; i++) rb[i] = '0;
    ref_store(32'h0, 4, 32'h20030000);
    ref_store(32'h4, 4, 32'h20040014);
    ref_store(32'h18, 4, 32'ha00300ff);
    reset_n = 0;
    tick(3);
    chk_reset_outputs("reset");
    reset_n = 1;
    tick(1);
    mon_en = 1;

    issue(0, 2'b10, 0, 32'h4, 0, 1, 32'h20040014);
    issue(0, 2'b00, 0, 32'h1b, 0, 1, 32'h000000ff);
    issue(0, 2'b00, 1, 32'h1b, 0, 1, 32'hffffffff);
    issue(0, 2'b01, 1, 32'h18, 0, 1, 32'hffffa003);
    issue(1, 2'b10, 0, 32'h700, 32'h0a0a0a0a, 0, 0);
    issue(0, 2'b10, 0, 32'h700, 0, 1, 32'h0a0a0a0a);
    issue(1, 2'b00, 0, 32'h702, 32'h12345655, 0, 0);
    issue(0, 2'b10, 0, 32'h700, 0, 1, 32'h0a0a550a);
    issue(0, 2'b10, 0, 32'h6, 0, 1, 32'h0);
    issue(0, 2'b11, 0, 32'h0, 0, 1, 32'h0);
    issue(1, 2'b01, 0, 32'h701, 32'hffff, 0, 0);
    drain();

    // Backpressure: response must stay put for five cycles with no new request accepted.
    force_rdy = 0;
    tick(1);
    issue(0, 2'b10, 0, 32'h0, 0, 1, 32'h20030000);
    ok = 0;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clk);
      if (bus.rsp_valid) ok = 1;
    end
    chk("hold_rsp_seen", 32'(ok), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("hold_req_ready", 32'(bus.req_ready), 32'd0);
    end
    @(posedge clk);
    #1 force_rdy = 1;
    drain();

    rnd_rdy = 1;
    for (int i = 0; i < 300; i++) begin
      a  = ($urandom_range(1) == 0) ? 32'($urandom_range(63)) : 32'h700 + 32'($urandom_range(15));
      sz = ($urandom_range(9) == 0) ? 2'b11 : 2'($urandom_range(2));
      issue(1'($urandom_range(1)), sz, 1'($urandom_range(1)), a, $urandom, 0, 0);
    end
    drain();
    rnd_rdy = 0;
    force_rdy = 1;
    tick(2);

`ifdef MEM_MASTER_STATS_EN
    chk("rd_count", 32'(rd_count), 32'(cnt_rd));
    chk("wr_count", 32'(wr_count), 32'(cnt_wr));
    chk("err_count", 32'(err_count), 32'(cnt_err));
`else
    chk("rd_count_off", 32'(rd_count), 32'd0);
    chk("wr_count_off", 32'(wr_count), 32'd0);
    chk("err_count_off", 32'(err_count), 32'd0);
`endif

    // Reset while a byte store waits on its read: nothing may be written.
    mon_en = 0;
    bus.req_valid = 1; bus.req_write = 1; bus.req_size = 2'b00;
    bus.req_signed = 0; bus.req_adr = 32'h704; bus.req_wdata = 32'h77;
    ok = 0;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      if (bus.req_ready) ok = 1;
    end
    chk("rst_accept", 32'(ok), 32'd1);
    @(posedge clk);
    #1 bus.req_valid = 0;
    reset_n = 0;
    #1;
    chk_reset_outputs("midrst");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("midrst_no_write", 32'(bus.memwrite), 32'd0);
    end
    @(posedge clk);
    #1 reset_n = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_idle_rsp", 32'(bus.rsp_valid), 32'd0);
      chk("post_rst_no_write", 32'(bus.memwrite), 32'd0);
    end

    for (int i = 0; i < 1024; i++)
      chk($sformatf("mem_%03h", i * 4), mem[i],
          {rb[4*i], rb[4*i+1], rb[4*i+2], rb[4*i+3]});

    $display("responses: loads %0d stores %0d errors %0d", cnt_rd, cnt_wr, cnt_err);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
